fir64_cmem_seq: RTL and testbench

- Sequencer for the 64-entry, 16-bit signed coefficient ROM (6-bit address `a`, data `q`).
- Accepts one input sample per handshake and stores it in an internal 64-deep circular history.
- Walks all 64 coefficient addresses to compute one FIR output with a single time-shared multiply-accumulate, then presents the rounded, saturated result on a valid/ready output.
- Sits between the sample producer and the downstream FPU/consumer; the coefficient ROM is instantiated outside and driven by this block.

---
 rtl/fir_pkg.sv | 30 +++
 rtl/fir64_cmem_seq_if.sv | 30 +++
 rtl/fir_hist_buf.sv | 36 +++
 rtl/fir64_cmem_seq.sv | 141 ++++++++++++++
 tb/tb_fir64_cmem_seq.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg : shared widths, FSM states and output rounding/saturation.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fir_pkg;
  localparam int DW    = 16;
  localparam int NTAP  = 64;
  localparam int AW    = 6;
  localparam int ACCW  = 2 * DW + AW;
  localparam int SHIFT = 15;

  localparam logic signed [ACCW-1:0] C_RND = ACCW'(1) << (SHIFT - 1);
  localparam logic signed [ACCW-1:0] C_HI  = ACCW'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACCW-1:0] C_LO  = ACCW'(-(2 ** (DW - 1)));

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Round half up, scale Q1.15 back to sample units, clamp to DW bits.
  function automatic logic signed [DW-1:0] sat16(input logic signed [ACCW-1:0] acc);
    logic signed [ACCW-1:0] w_r;
    w_r = (acc + C_RND) >>> SHIFT;
    if (w_r > C_HI)      sat16 = C_HI[DW-1:0];
    else if (w_r < C_LO) sat16 = C_LO[DW-1:0];
    else                 sat16 = w_r[DW-1:0];
  endfunction
endpackage

`default_nettype wire

// File: rtl/fir64_cmem_seq_if.sv
// ---------------------------------------------------------------------------
// fir64_cmem_seq_if : sample input, coefficient ROM and result handshakes.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fir64_cmem_seq_if;
  import fir_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic [AW-1:0]        cmem_a;
  logic signed [DW-1:0] cmem_q;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;

  modport master (
    output in_valid, in_data, cmem_q, out_ready,
    input  in_ready, cmem_a, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, cmem_q, out_ready,
    output in_ready, cmem_a, out_valid, out_data
  );
endinterface

`default_nettype wire

// File: rtl/fir_hist_buf.sv
// ---------------------------------------------------------------------------
// fir_hist_buf : NTAP x DW circular sample history, async read, sync clear.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fir_hist_buf
  import fir_pkg::*;
(
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 i_clr,
  input  wire logic                 i_we,
  input  wire logic [AW-1:0]        i_waddr,
  input  wire logic signed [DW-1:0] i_wdata,
  input  wire logic [AW-1:0]        i_raddr,
  output logic signed [DW-1:0]      o_rdata
);

  logic signed [DW-1:0] r_mem [NTAP];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAP; i++) r_mem[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < NTAP; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/fir64_cmem_seq.sv
// ---------------------------------------------------------------------------
// fir64_cmem_seq : 64-tap FIR sequencer driving an external coefficient ROM
//                  through one time-shared, pipelined multiply-accumulate.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fir64_cmem_seq
  import fir_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          clr,
  fir64_cmem_seq_if.slave    bus,
  output logic               busy
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_newest;
  logic [AW-1:0]          r_tap;
  logic signed [ACCW-1:0] r_acc;
  logic signed [2*DW-1:0] r_prod;
  logic                   r_prod_v;
  logic signed [DW-1:0]   r_out_data;

  logic                   w_in_ready;
  logic                   w_out_valid;
  logic                   w_busy;
  logic [AW-1:0]          w_cmem_a;
  logic                   w_accept;
  logic signed [DW-1:0]   w_sample;
  logic signed [2*DW-1:0] w_q_ext;
  logic signed [2*DW-1:0] w_s_ext;
  logic signed [2*DW-1:0] w_prod;
  logic signed [ACCW-1:0] w_acc_sum;

  assign w_accept  = (r_state == IDLE) && bus.in_valid && !clr;
  assign w_q_ext   = {{DW{bus.cmem_q[DW-1]}}, bus.cmem_q};
  assign w_s_ext   = {{DW{w_sample[DW-1]}}, w_sample};
  assign w_prod    = w_q_ext * w_s_ext;
  assign w_acc_sum = r_acc + ACCW'(r_prod);

  // Tap k reads the sample k positions older than the newest one.
  fir_hist_buf u_hist (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (clr),
    .i_we    (w_accept),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.in_data),
    .i_raddr (r_newest - r_tap),
    .o_rdata (w_sample)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    w_cmem_a    = '0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        w_busy   = 1'b1;
        w_cmem_a = r_tap;
        if (r_tap == AW'(NTAP - 1)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_busy      = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (clr) w_state_nxt = IDLE;
  end

  // Products lag the tap by one cycle; DRAIN folds in the final product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_newest   <= '0;
      r_tap      <= '0;
      r_acc      <= '0;
      r_prod     <= '0;
      r_prod_v   <= 1'b0;
      r_out_data <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_tap    <= '0;
      r_acc    <= '0;
      r_prod_v <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_newest <= r_wr_ptr;
            r_wr_ptr <= r_wr_ptr + AW'(1);
            r_tap    <= '0;
            r_acc    <= '0;
            r_prod_v <= 1'b0;
          end
        end
        RUN: begin
          r_prod   <= w_prod;
          r_prod_v <= 1'b1;
          if (r_prod_v) r_acc <= w_acc_sum;
          r_tap    <= r_tap + AW'(1);
        end
        DRAIN: begin
          r_acc      <= w_acc_sum;
          r_prod_v   <= 1'b0;
          r_out_data <= sat16(w_acc_sum);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.cmem_a    = w_cmem_a;
  assign busy          = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_fir64_cmem_seq.sv
// ---------------------------------------------------------------------------
// tb_fir64_cmem_seq : directed bench for fir64_cmem_seq with a modelled ROM.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fir64_cmem_seq;
  import fir_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  fir64_cmem_seq_if bus ();

  fir64_cmem_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Symmetric coefficient set: h0=-1, h2=1, h31=h32=0x2500, h63=-1.
  function automatic logic signed [15:0] coef(input int k);
    int m;
    int v;
    m = (k < 32) ? k : 63 - k;
    if (m == 0)       v = -1;
    else if (m == 1)  v = 0;
    else if (m == 2)  v = 1;
    else if (m == 31) v = 9472;
    else              v = ((m % 2) != 0 ? -9 : 9) * m * m;
    return 16'(v);
  endfunction

  always_comb bus.cmem_q = coef(int'(bus.cmem_a));

  logic signed [15:0] hq[$];

  task automatic push_hist(input logic signed [15:0] d);
    hq.push_front(d);
    if (hq.size() > 64) void'(hq.pop_back());
  endtask

  function automatic logic [15:0] model_y();
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < hq.size(); k++) acc += longint'(coef(k)) * longint'(hq[k]);
    r = (acc + 16384) >>> 15;
    if (r > 32767)  return 16'h7FFF;
    if (r < -32768) return 16'h8000;
    return 16'(r);
  endfunction

  function automatic logic signed [15:0] satpat(input int k, input bit neg);
    logic signed [15:0] v;
    v = (coef(k) >= 0) ? 16'sh7FFF : 16'sh8001;
    return neg ? -v : v;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 16'(bus.in_ready), 16'd1);
  endtask

  task automatic send(input logic signed [15:0] d);
    wait_idle();
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
    push_hist(d);
  endtask

  task automatic get(output logic [15:0] y);
    int n = 0;
    while (!bus.out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_wait", 16'(bus.out_valid), 16'd1);
    y = bus.out_data;
    if (bus.out_ready) @(negedge clk);
  endtask

  task automatic xfer(input logic signed [15:0] d, output logic [15:0] y);
    send(d);
    get(y);
  endtask

  task automatic watch_quiet(input string tag);
    bit seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk(tag, 16'(seen), 16'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] y;
    logic [15:0] yimp [64];
    logic [15:0] hold;
    bit          seq_ok, rdy_ok, early, bp_ok;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_in_ready",  16'(bus.in_ready),  16'd1);
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_busy",      16'(busy),          16'd0);
    chk("rst_cmem_a",    16'(bus.cmem_a),    16'd0);
    chk("rst_out_data",  bus.out_data,       16'h0000);

    rst_n = 1'b1;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_in_ready", 16'(bus.in_ready), 16'd1);
    hq.delete();

    // Impulse response
    for (int i = 0; i < 64; i++) xfer((i == 0) ? 16'sh7FFF : 16'sh0000, yimp[i]);
    chk("imp_y0",  yimp[0],  16'hFFFF);
    chk("imp_y2",  yimp[2],  16'h0001);
    chk("imp_y31", yimp[31], 16'h2500);
    chk("imp_y32", yimp[32], 16'h2500);
    chk("imp_y63", yimp[63], 16'hFFFF);

    // Latency and address sequence; loop index j is the cycle offset from accept
    wait_idle();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sh0100;
    @(negedge clk);
    bus.in_valid = 1'b0;
    push_hist(16'sh0100);
    seq_ok = 1'b1;
    rdy_ok = 1'b1;
    early  = 1'b0;
    hold   = '0;
    for (int j = 1; j <= 67; j++) begin
      if (j <= 64 && (bus.cmem_a !== 6'(j - 1) || busy !== 1'b1)) seq_ok = 1'b0;
      if (j <= 66 && bus.in_ready !== 1'b0) rdy_ok = 1'b0;
      if (j < 66 && bus.out_valid) early = 1'b1;
      if (j == 65) chk("lat_drain_busy", 16'(busy), 16'd1);
      if (j == 66) begin
        chk("lat_out_valid", 16'(bus.out_valid), 16'd1);
        hold = bus.out_data;
      end
      if (j == 67) begin
        chk("lat_in_ready_after_hs", 16'(bus.in_ready),  16'd1);
        chk("lat_out_valid_after",   16'(bus.out_valid), 16'd0);
      end
      if (j < 67) @(negedge clk);
    end
    chk("lat_cmem_seq",    16'(seq_ok), 16'd1);
    chk("lat_in_ready_lo", 16'(rdy_ok), 16'd1);
    chk("lat_no_early",    16'(early),  16'd0);
    chk("lat_data",        hold,        model_y());

    // Saturation, both polarities
    for (int i = 0; i < 64; i++) xfer(satpat(63 - i, 1'b0), y);
    chk("sat_hi", y, 16'h7FFF);
    for (int i = 0; i < 64; i++) xfer(satpat(63 - i, 1'b1), y);
    chk("sat_lo", y, 16'h8000);

    // Backpressure
    bus.out_ready = 1'b0;
    send(16'sh1234);
    get(hold);
    chk("bp_data", hold, model_y());
    bp_ok = 1'b1;
    for (int j = 0; j < 10; j++) begin
      bus.in_valid = j[0];
      bus.in_data  = 16'sh5555;
      @(negedge clk);
      if (!bus.out_valid || bus.out_data !== hold || bus.in_ready) bp_ok = 1'b0;
    end
    bus.in_valid  = 1'b0;
    chk("bp_stable", 16'(bp_ok), 16'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_out_valid", 16'(bus.out_valid), 16'd0);
    chk("bp_hs_in_ready",  16'(bus.in_ready),  16'd1);
    repeat (5) @(negedge clk);
    chk("bp_no_accept", 16'(busy), 16'd0);

    // Wrap-around with random samples
    for (int i = 0; i < 130; i++) begin
      xfer(16'($urandom), y);
      chk("wrap", y, model_y());
    end

    // clr wins over a simultaneous accept
    wait_idle();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sh7777;
    clr          = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    clr          = 1'b0;
    chk("clr_accept_busy",     16'(busy),         16'd0);
    chk("clr_accept_in_ready", 16'(bus.in_ready), 16'd1);
    hq.delete();

    // Abort by clr in RUN cycle 20
    send(16'sh4000);
    repeat (19) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("abort_in_ready",  16'(bus.in_ready),  16'd1);
    chk("abort_busy",      16'(busy),          16'd0);
    chk("abort_out_valid", 16'(bus.out_valid), 16'd0);
    hq.delete();
    watch_quiet("abort_no_out");
    xfer(16'sh7FFF, y);
    chk("abort_y0", y, 16'hFFFF);

    // Reset while a result waits in DONE
    bus.out_ready = 1'b0;
    send(16'sh7FFF);
    get(y);
    rst_n = 1'b0;
    #1;
    chk("rst_done_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_done_out_data",  bus.out_data,       16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rst_done_in_ready", 16'(bus.in_ready), 16'd1);
    hq.delete();
    watch_quiet("rst_no_out");
    xfer(16'sh7FFF, y);
    chk("rst_y0", y, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
